// File: rtl/eviction_write_buffer.sv
// Single-entry victim buffer between L2 and memory: holds one evicted line,
// serves read hits from it and drains it to memory when idle or displaced.
module eviction_write_buffer #(
  parameter int s_offset  = 5,
  parameter int s_line    = 8 * (2 ** s_offset),
  parameter int idle_wait = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [s_line-1:0] mem_wdata256,
  output logic [s_line-1:0] mem_rdata256,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [s_line-1:0] pmem_wdata,
  input  logic [s_line-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int          TAG_W    = 32 - s_offset;
  localparam logic [3:0]  IDLE_MAX = 4'(idle_wait);

  typedef enum logic [2:0] {IDLE, HIT_RESP, WR_ACK, READ_MEM, DRAIN} state_t;

  state_t             state, next_state;
  logic               valid;
  logic [TAG_W-1:0]   tag;
  logic [s_line-1:0]  data;
  logic [3:0]         idle_cnt;
  logic [TAG_W-1:0]   req_tag;
  logic               tag_hit;
  logic               idle_no_req;
  logic               capture;
  logic               unused_addr_bits;

  assign req_tag          = mem_address[31:s_offset];
  assign tag_hit          = valid && (tag == req_tag);
  assign idle_no_req      = (state == IDLE) && !mem_read && !mem_write;
  assign capture          = (state == IDLE) && mem_write && !mem_read && !valid;
  assign unused_addr_bits = ^mem_address[s_offset-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A read wins over a simultaneous write; a write into a full buffer first drains it.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (mem_read)                             next_state = tag_hit ? HIT_RESP : READ_MEM;
        else if (mem_write)                       next_state = valid ? DRAIN : WR_ACK;
        else if (valid && idle_cnt == IDLE_MAX)   next_state = DRAIN;
      end
      HIT_RESP: next_state = IDLE;
      WR_ACK:   next_state = IDLE;
      READ_MEM: if (pmem_resp) next_state = IDLE;
      DRAIN:    if (pmem_resp) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata256 = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    unique case (state)
      HIT_RESP: begin
        mem_resp     = 1'b1;
        mem_rdata256 = data;
      end
      WR_ACK: mem_resp = 1'b1;
      READ_MEM: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, {s_offset{1'b0}}};
        if (pmem_resp) begin
          mem_resp     = 1'b1;
          mem_rdata256 = pmem_rdata;
        end
      end
      DRAIN: begin
        pmem_write   = 1'b1;
        pmem_address = {tag, {s_offset{1'b0}}};
        pmem_wdata   = data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      tag   <= req_tag;
      data  <= mem_wdata256;
    end else if (state == DRAIN && pmem_resp) begin
      valid <= 1'b0;
    end
  end

  // Counts quiet cycles with a buffered line; saturates so the drain condition holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       idle_cnt <= '0;
    else if (idle_no_req && valid) idle_cnt <= (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 4'd1;
    else                           idle_cnt <= '0;
  end

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Bench for eviction_write_buffer: directed scenarios plus random traffic,
// checked against a coherent-memory model (memory image + one resident line).
module tb_eviction_write_buffer;

  localparam int IDLE_WAIT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata256, mem_rdata256;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int n_cmp = 0;
  int n_fail = 0;
  int mem_lat = 2;
  int waited = 0;

  logic [255:0] mem_img [logic [26:0]];
  logic         resident_valid = 1'b0;
  logic [26:0]  resident_tag = '0;
  logic [255:0] resident_data = '0;

  eviction_write_buffer #(.s_offset(5), .s_line(256), .idle_wait(IDLE_WAIT)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata256(mem_wdata256), .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [255:0] mem_value(input logic [26:0] t);
    if (mem_img.exists(t)) return mem_img[t];
    return {8{{5'b0, t} ^ 32'h5A5A_0000}};
  endfunction

  // Memory model: answers after mem_lat cycles of a held request, garbage data otherwise.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      pmem_resp  = 1'b0;
      pmem_rdata = rand_line();
      if (rst || !(pmem_read || pmem_write)) waited = 0;
      else if (waited + 1 >= mem_lat) begin
        pmem_resp = 1'b1;
        waited    = 0;
        if (pmem_read) pmem_rdata = mem_value(pmem_address[31:5]);
      end else waited++;
    end
  end

  // Drains must write back exactly the resident line; memory then owns it.
  always @(negedge clk) begin
    if (!rst) begin
      if (pmem_read || pmem_write) checkOutput("pmem_excl", 256'(pmem_read & pmem_write), 256'd0);
      if (pmem_write && pmem_resp) begin
        checkOutput("drain_valid", 256'(resident_valid), 256'd1);
        checkOutput("drain_addr", 256'(pmem_address), 256'({resident_tag, 5'b0}));
        checkOutput("drain_data", pmem_wdata, resident_data);
        mem_img[resident_tag] = resident_data;
        resident_valid = 1'b0;
      end
      if (pmem_read && pmem_resp)
        checkOutput("rd_addr", 256'(pmem_address), 256'({mem_address[31:5], 5'b0}));
    end
  end

  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [255:0] wdata, output int lat,
                               output int rd_cyc, output int wr_cyc, output logic [255:0] rdata);
    logic [255:0] exp;
    mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata256 = wdata;
    lat = 0; rd_cyc = 0; wr_cyc = 0; rdata = '0;
    do begin
      @(negedge clk);
      lat++;
      if (pmem_read)  rd_cyc++;
      if (pmem_write) wr_cyc++;
    end while (!mem_resp && lat < 200);
    if (!mem_resp) checkOutput("req_timeout", 256'd0, 256'd1);
    else if (rd) begin
      exp = (resident_valid && resident_tag == addr[31:5]) ? resident_data : mem_value(addr[31:5]);
      rdata = mem_rdata256;
      checkOutput("rd_data", mem_rdata256, exp);
    end else begin
      resident_valid = 1'b1;
      resident_tag   = addr[31:5];
      resident_data  = wdata;
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic wait_drain_start();
    int n = 0;
    while (!pmem_write && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("drain_start", 256'(pmem_write), 256'd1);
  endtask

  initial begin
    int lat, rc, wc, n;
    logic [255:0] rdata, d1, d2, d3, d4;
    logic [31:0] bases [4];
    bases = '{32'h0000_1040, 32'h0000_2000, 32'h0000_3000, 32'h7FE0_0000};
    d1 = rand_line(); d2 = rand_line(); d3 = rand_line(); d4 = rand_line();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata256 = '0;
    #1;
    checkOutput("rst_mem_resp", 256'(mem_resp), 256'd0);
    checkOutput("rst_pmem_read", 256'(pmem_read), 256'd0);
    checkOutput("rst_pmem_write", 256'(pmem_write), 256'd0);
    checkOutput("rst_pmem_addr", 256'(pmem_address), 256'd0);
    checkOutput("rst_pmem_wdata", pmem_wdata, 256'd0);
    checkOutput("rst_rdata", mem_rdata256, 256'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(0, 1, 32'h0000_1040, d1, lat, rc, wc, rdata);
    checkOutput("wr_empty_lat", 256'(lat), 256'd2);
    checkOutput("wr_empty_pmem", 256'(rc + wc), 256'd0);

    applyStimulus(1, 0, 32'h0000_105C, '0, lat, rc, wc, rdata);
    checkOutput("hit_lat", 256'(lat), 256'd2);
    checkOutput("hit_no_pmem", 256'(rc), 256'd0);
    checkOutput("hit_data_d1", rdata, d1);

    mem_img[27'(32'h0000_2000 >> 5)] = d2;
    mem_lat = 3;
    applyStimulus(1, 0, 32'h0000_2000, '0, lat, rc, wc, rdata);
    checkOutput("miss_rd_cycles", 256'(rc), 256'd3);
    checkOutput("miss_lat", 256'(lat), 256'd4);
    checkOutput("miss_data_d2", rdata, d2);
    applyStimulus(1, 0, 32'h0000_1040, '0, lat, rc, wc, rdata);
    checkOutput("still_valid_no_pmem", 256'(rc), 256'd0);
    checkOutput("still_valid_d1", rdata, d1);

    mem_lat = 2;
    n = 0;
    do begin @(negedge clk); n++; end while (!pmem_write && n < 50);
    checkOutput("bg_drain_delay", 256'(n), 256'(IDLE_WAIT + 2));
    @(posedge clk); #1;
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("bg_drain_done", 256'(resident_valid), 256'd0);

    applyStimulus(0, 1, 32'h0000_1040, d1, lat, rc, wc, rdata);
    applyStimulus(0, 1, 32'h0000_3000, d3, lat, rc, wc, rdata);
    checkOutput("forced_wr_cycles", 256'(wc), 256'd2);
    checkOutput("forced_lat", 256'(lat), 256'd5);
    wait_drain_start();
    applyStimulus(1, 0, 32'h0000_3000, '0, lat, rc, wc, rdata);
    checkOutput("rd_after_drain_miss", 256'(rc > 0), 256'd1);
    checkOutput("rd_after_drain_d3", rdata, d3);

    applyStimulus(0, 1, 32'h0000_1040, d4, lat, rc, wc, rdata);
    mem_lat = 4;
    wait_drain_start();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_pmem_write", 256'(pmem_write), 256'd0);
    checkOutput("midrst_pmem_addr", 256'(pmem_address), 256'd0);
    checkOutput("midrst_mem_resp", 256'(mem_resp), 256'd0);
    resident_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1, 0, 32'h0000_1040, '0, lat, rc, wc, rdata);
    checkOutput("post_rst_miss", 256'(rc > 0), 256'd1);
    checkOutput("post_rst_d1", rdata, d1);

    for (int i = 0; i < 250; i++) begin
      int r, gap;
      bit rd, wr, was_empty;
      logic [31:0] addr;
      r  = $urandom_range(0, 19);
      rd = (r < 9) || (r >= 18);
      wr = (r >= 9);
      addr = bases[$urandom_range(0, 3)] | 32'($urandom_range(0, 31));
      mem_lat = $urandom_range(1, 4);
      was_empty = !resident_valid;
      applyStimulus(rd, wr, addr, rand_line(), lat, rc, wc, rdata);
      if (wr && !rd && was_empty) checkOutput("rnd_wr_empty_lat", 256'(lat), 256'd2);
      gap = $urandom_range(0, 9);
      if (gap == 9) begin
        repeat (20) begin @(posedge clk); #1; end
        checkOutput("rnd_bg_drain", 256'(resident_valid), 256'd0);
      end else begin
        repeat (gap) begin @(posedge clk); #1; end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/eviction_write_buffer.md
EVICTION_WRITE_BUFFER -- requirements
Module: eviction_write_buffer

Interface
REQ-001 SHALL have parameter s_offset, default 5, byte-offset bits per cacheline.
REQ-002 SHALL have parameter s_line, default 256, cacheline width in bits (8*2**s_offset).
REQ-003 SHALL have parameter idle_wait, default 4, consecutive idle cycles before a background drain starts (1..15).
REQ-004 SHALL have a single clock and asynchronous active-high reset: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high).
REQ-005 SHALL have upstream (L2-facing) ports: mem_read input 1 (line read request); mem_write input 1 (victim writeback request); mem_address input 32 (line address); mem_wdata256 input s_line (victim data); mem_rdata256 output s_line (read data); mem_resp output 1 (request complete).
REQ-006 SHALL have downstream (memory-facing) ports: pmem_read output 1; pmem_write output 1; pmem_address output 32; pmem_wdata output s_line; pmem_rdata input s_line; pmem_resp input 1 (one-cycle completion).

Function
REQ-007 SHALL hold one buffer entry: valid bit, line tag (address[31:s_offset]), s_line data.
REQ-008 SHALL implement FSM states IDLE, HIT_RESP, WR_ACK, READ_MEM, DRAIN.
REQ-009 SHALL treat upstream requests as level-held until mem_resp; mem_read and mem_write both high SHALL be serviced as a read.
REQ-010 IDLE, mem_read, valid and tag match: SHALL go to HIT_RESP; no pmem access.
REQ-011 HIT_RESP: SHALL drive mem_resp=1 and mem_rdata256=buffer data for exactly one cycle, then IDLE; entry stays valid.
REQ-012 IDLE, mem_read, miss or entry invalid: SHALL go to READ_MEM.
REQ-013 READ_MEM: SHALL drive pmem_read=1, pmem_address = mem_address with low s_offset bits zero, until pmem_resp; in the pmem_resp cycle SHALL drive mem_resp=1, mem_rdata256=pmem_rdata (combinational pass-through), next state IDLE.
REQ-014 IDLE, mem_write, entry invalid: SHALL capture tag and mem_wdata256 at the edge, set valid, go to WR_ACK.
REQ-015 WR_ACK: SHALL drive mem_resp=1 for exactly one cycle, then IDLE.
REQ-016 IDLE, mem_write, entry valid: SHALL go to DRAIN (forced drain); write accepted per REQ-014 after the drain returns to IDLE.
REQ-017 Idle counter: SHALL increment each IDLE cycle with valid=1 and no request, saturate at idle_wait, clear on any request, any non-IDLE state, or valid=0.
REQ-018 IDLE, valid, no request, counter == idle_wait: SHALL go to DRAIN (background drain).
REQ-019 DRAIN: SHALL drive pmem_write=1, pmem_address = {tag, s_offset zeros}, pmem_wdata = buffer data until pmem_resp; on pmem_resp SHALL clear valid and go to IDLE.
REQ-020 A started drain SHALL NOT be aborted; requests arriving during DRAIN SHALL wait and be evaluated in IDLE afterward (a read to the drained line then misses and goes to memory).
REQ-021 SHALL never assert pmem_read and pmem_write together; both SHALL be 0 outside READ_MEM/DRAIN.
REQ-022 mem_resp SHALL be 0 outside HIT_RESP, WR_ACK and the pmem_resp cycle of READ_MEM; requests present during a response cycle SHALL NOT be re-accepted.
REQ-023 Tag compare SHALL ignore address bits [s_offset-1:0].
REQ-024 pmem_resp outside READ_MEM/DRAIN SHALL be ignored.

Reset
REQ-025 rst high SHALL immediately force IDLE, valid=0, counter=0, and mem_resp, pmem_read, pmem_write=0; pmem_address, pmem_wdata, mem_rdata256 SHALL read 0.
REQ-026 Reset mid-DRAIN or mid-READ_MEM SHALL drop the transaction and buffered line without response.

Verification
REQ-027 Empty buffer, mem_write addr 0x0000_1040, data D1 -> mem_resp one cycle 2 cycles after request; no pmem activity.
REQ-028 Entry 0x0000_1040/D1 valid, mem_read 0x0000_105C the next cycle -> HIT_RESP, mem_rdata256=D1, no pmem_read.
REQ-029 Entry valid, mem_read 0x0000_2000, memory answers 3 cycles later with D2 -> pmem_read held 3 cycles at 0x0000_2000, mem_resp with D2 in pmem_resp cycle; entry still valid.
REQ-030 Entry 0x0000_1040 valid, no requests -> after 4 idle cycles pmem_write with address 0x0000_1040, data D1; valid clears on pmem_resp.
REQ-031 Entry valid, mem_write 0x0000_3000/D3 -> forced drain of 0x0000_1040/D1 first, then D3 captured and mem_resp; mem_read during the drain waits until drain completes.
REQ-032 rst asserted mid-DRAIN -> outputs 0 same cycle, subsequent read of 0x0000_1040 goes to memory.
